// File: rtl/img_proc_pkg.sv
// Shared constants, pixel/gradient types and small arithmetic helpers
// for the image-processing pipeline stages.
package img_proc_pkg;

   localparam int H_DISP   = 640;
   localparam int V_DISP   = 480;
   localparam int PIX_W    = 8;
   localparam int GRAD_W   = 11;
   localparam int PIPE_LAT = 4;

   localparam logic [PIX_W-1:0] EDGE_ON  = 8'hFF;
   localparam logic [PIX_W-1:0] EDGE_OFF = 8'h00;

   typedef logic        [PIX_W-1:0]  pix_t;
   typedef logic signed [GRAD_W-1:0] grad_t;
   typedef logic        [GRAD_W-1:0] mag_t;

   // Counter/address width; at least 2 bits so "< 2" border tests stay meaningful.
   function automatic int addr_bits(input int n);
      return (n > 2) ? $clog2(n) : 2;
   endfunction

   function automatic grad_t weighted_sum(input pix_t a, input pix_t b, input pix_t c);
      return grad_t'(a) + (grad_t'(b) <<< 1) + grad_t'(c);
   endfunction

   function automatic mag_t abs_grad(input grad_t g);
      return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line pixel store. The write lands on the clock edge while dout shows the
// word held before it, so a cascaded buffer receives the line being evicted.
module sobel_line_buffer
   import img_proc_pkg::*;
#(
   parameter int DEPTH = img_proc_pkg::H_DISP
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [addr_bits(DEPTH)-1:0]  addr,
   input  pix_t                         din,
   output pix_t                         dout
);

   pix_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
   end

   assign dout = mem[addr];

endmodule

// File: rtl/sobel_edge_detect.sv
// Sobel edge detector: 3x3 window from two cascaded line buffers, |gx|+|gy|
// thresholded to a binary map, with syncs/DE delayed to match the data path.
module sobel_edge_detect
   import img_proc_pkg::*;
#(
   parameter int          H_DISP = img_proc_pkg::H_DISP,
   parameter int          V_DISP = img_proc_pkg::V_DISP,
   parameter int unsigned THRESH = 96
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             gray_hsync,
   input  logic             gray_vsync,
   input  logic             gray_de,
   input  logic [PIX_W-1:0] gray_data,
   output logic             edge_hsync,
   output logic             edge_vsync,
   output logic             edge_de,
   output logic [PIX_W-1:0] edge_data
);

   localparam int               COL_W    = addr_bits(H_DISP);
   localparam int               ROW_W    = addr_bits(V_DISP);
   localparam logic [COL_W-1:0] COL_MAX  = COL_W'(H_DISP - 1);
   localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(V_DISP - 1);
   localparam mag_t             THRESH_V = mag_t'(THRESH);

   logic [COL_W-1:0]    col;
   logic [ROW_W-1:0]    row;
   logic [PIPE_LAT-1:0] de_pipe;
   logic [PIPE_LAT-1:0] hs_pipe;
   logic [PIPE_LAT-1:0] vs_pipe;
   logic [PIPE_LAT-2:0] border_pipe;
   logic                border_now;
   pix_t                lb0_out;
   pix_t                lb1_out;
   pix_t                win [3][3];
   grad_t               gx;
   grad_t               gy;
   mag_t                mag;

   // de_pipe[0] is gray_de one cycle late, so (!gray_de && de_pipe[0]) marks the line end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (!gray_vsync) begin
         col <= '0;
         row <= '0;
      end else if (gray_de) begin
         if (col != COL_MAX) begin
            col <= col + 1'b1;
         end
      end else if (de_pipe[0]) begin
         col <= '0;
         if (row != ROW_MAX) begin
            row <= row + 1'b1;
         end
      end
   end

   sobel_line_buffer #(.DEPTH(H_DISP)) u_lb0 (
      .clk  (clk),
      .we   (gray_de),
      .addr (col),
      .din  (gray_data),
      .dout (lb0_out)
   );

   sobel_line_buffer #(.DEPTH(H_DISP)) u_lb1 (
      .clk  (clk),
      .we   (gray_de),
      .addr (col),
      .din  (lb0_out),
      .dout (lb1_out)
   );

   // win[r][c]: r=0 oldest line, c=0 leftmost column; right column enters from the buffers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win[r][c] <= '0;
            end
         end
      end else if (gray_de) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= lb1_out;
         win[1][2] <= lb0_out;
         win[2][2] <= gray_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gx        <= '0;
         gy        <= '0;
         mag       <= '0;
         edge_data <= EDGE_OFF;
      end else begin
         gx  <= weighted_sum(win[0][2], win[1][2], win[2][2])
              - weighted_sum(win[0][0], win[1][0], win[2][0]);
         gy  <= weighted_sum(win[2][0], win[2][1], win[2][2])
              - weighted_sum(win[0][0], win[0][1], win[0][2]);
         mag <= abs_grad(gx) + abs_grad(gy);
         edge_data <= (de_pipe[PIPE_LAT-2] && !border_pipe[PIPE_LAT-2] && (mag >= THRESH_V))
                      ? EDGE_ON : EDGE_OFF;
      end
   end

   assign border_now = (row < ROW_W'(2)) || (col < COL_W'(2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_pipe     <= '0;
         hs_pipe     <= '1;
         vs_pipe     <= '1;
         border_pipe <= '0;
      end else begin
         de_pipe     <= {de_pipe[PIPE_LAT-2:0], gray_de};
         hs_pipe     <= {hs_pipe[PIPE_LAT-2:0], gray_hsync};
         vs_pipe     <= {vs_pipe[PIPE_LAT-2:0], gray_vsync};
         border_pipe <= {border_pipe[PIPE_LAT-3:0], border_now};
      end
   end

   assign edge_de    = de_pipe[PIPE_LAT-1];
   assign edge_hsync = hs_pipe[PIPE_LAT-1];
   assign edge_vsync = vs_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Directed bench for sobel_edge_detect on a reduced 16x10 frame: frame table,
// per-pixel check table, 4-cycle latency tracking and a mid-frame reset.
module tb_sobel_edge_detect;

   localparam int H         = 16;
   localparam int V         = 10;
   localparam int HBLANK    = 8;
   localparam int LINES     = V + 4;
   localparam int VSTEP_COL = 5;
   localparam int HSTEP_ROW = 4;
   localparam int NFRAMES   = 7;

   typedef struct {
      int pattern;
      int level;
      int rst_row;
      int rst_col;
      int exp_ones;
   } frame_t;

   typedef struct {
      int frame;
      int row;
      int col;
      int exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       gray_hsync = 1'b1;
   logic       gray_vsync = 1'b1;
   logic       gray_de = 1'b0;
   logic [7:0] gray_data = 8'h00;
   logic       edge_hsync;
   logic       edge_vsync;
   logic       edge_de;
   logic [7:0] edge_data;

   int         compared = 0;
   int         mismatched = 0;
   bit         mon_en = 1'b0;
   int         lat_err = 0;
   int         idle_err = 0;
   int         de_cnt = 0;
   int         one_cnt = 0;
   int         orow = 0;
   int         ocol = 0;
   logic       prev_de = 1'b0;
   logic [2:0] hde = 3'b000;
   logic [2:0] hhs = 3'b111;
   logic [2:0] hvs = 3'b111;
   logic [7:0] cap [V][H];
   frame_t     frames [NFRAMES];
   vec_t       vecs [$];

   sobel_edge_detect #(.H_DISP(H), .V_DISP(V), .THRESH(96)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .gray_hsync (gray_hsync),
      .gray_vsync (gray_vsync),
      .gray_de    (gray_de),
      .gray_data  (gray_data),
      .edge_hsync (edge_hsync),
      .edge_vsync (edge_vsync),
      .edge_de    (edge_de),
      .edge_data  (edge_data)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input int actual, input int required);
      compared++;
      if (actual != required) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
      end
   endtask

   function automatic logic [7:0] pix(input int pattern, input int level, input int r, input int c);
      case (pattern)
         0:       return 8'h80;
         1:       return (c >= VSTEP_COL) ? 8'(level) : 8'h00;
         default: return (r >= HSTEP_ROW) ? 8'(level) : 8'h00;
      endcase
   endfunction

   // One full frame: 2 vsync lines, 1 back-porch line, V active lines, 1 front-porch line.
   task automatic apply_stimulus(input int pattern, input int level, input int rst_row, input int rst_col);
      int hold;
      hold = 0;
      for (int ln = 0; ln < LINES; ln++) begin
         for (int x = 0; x < H + HBLANK; x++) begin
            int r;
            int c;
            bit act;
            @(negedge clk);
            if (!rst_n) begin
               hold++;
               if (hold >= 3) rst_n = 1'b1;
            end
            r = ln - 3;
            c = x - 4;
            act = (ln >= 3) && (r < V) && (x >= 4) && (c < H);
            gray_vsync = (ln >= 2);
            gray_hsync = !((x >= H + 5) && (x < H + 7));
            gray_de    = act;
            gray_data  = act ? pix(pattern, level, r, c) : 8'h00;
            if (act && r == rst_row && c == rst_col) begin
               rst_n = 1'b0;
               #1;
               check_output("midreset edge_data", int'(edge_data), 0);
               check_output("midreset edge_de", int'(edge_de), 0);
               check_output("midreset edge_hsync", int'(edge_hsync), 1);
               check_output("midreset edge_vsync", int'(edge_vsync), 1);
            end
         end
      end
   endtask

   // Output monitor, sampled 1 time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (edge_de !== hde[2] || edge_hsync !== hhs[2] || edge_vsync !== hvs[2]) lat_err++;
            if (!edge_de && edge_data !== 8'h00) idle_err++;
         end
         hde = {hde[1:0], gray_de};
         hhs = {hhs[1:0], gray_hsync};
         hvs = {hvs[1:0], gray_vsync};
         if (!edge_vsync) begin
            orow = 0;
            ocol = 0;
            de_cnt = 0;
            one_cnt = 0;
            for (int r = 0; r < V; r++) begin
               for (int c = 0; c < H; c++) cap[r][c] = 8'h55;
            end
         end else if (edge_de) begin
            if (orow < V && ocol < H) cap[orow][ocol] = edge_data;
            ocol++;
            de_cnt++;
            if (edge_data == 8'hFF) one_cnt++;
         end else if (prev_de) begin
            ocol = 0;
            orow++;
         end
         prev_de = edge_de;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      frames[0] = '{0, 128, -1, -1, 0};
      frames[1] = '{1, 200, -1, -1, 2 * (V - 2)};
      frames[2] = '{2, 200, -1, -1, 2 * (H - 2)};
      frames[3] = '{1, 24,  -1, -1, 2 * (V - 2)};
      frames[4] = '{1, 23,  -1, -1, 0};
      frames[5] = '{1, 200,  5,  8, -1};
      frames[6] = '{1, 200, -1, -1, 2 * (V - 2)};

      vecs.push_back('{0, 5, 5, 0});
      vecs.push_back('{0, 9, 15, 0});
      vecs.push_back('{1, 2, 5, 255});
      vecs.push_back('{1, 9, 6, 255});
      vecs.push_back('{1, 3, 4, 0});
      vecs.push_back('{1, 3, 7, 0});
      vecs.push_back('{1, 1, 5, 0});
      vecs.push_back('{1, 5, 0, 0});
      vecs.push_back('{2, 4, 2, 255});
      vecs.push_back('{2, 5, 15, 255});
      vecs.push_back('{2, 3, 8, 0});
      vecs.push_back('{2, 6, 8, 0});
      vecs.push_back('{2, 4, 1, 0});
      vecs.push_back('{3, 4, 5, 255});
      vecs.push_back('{3, 4, 6, 255});
      vecs.push_back('{3, 4, 7, 0});
      vecs.push_back('{4, 4, 5, 0});
      vecs.push_back('{4, 4, 6, 0});
      vecs.push_back('{6, 7, 5, 255});
      vecs.push_back('{6, 7, 6, 255});
      vecs.push_back('{6, 7, 3, 0});

      // Inputs held non-idle during reset: outputs must still show idle values.
      gray_hsync = 1'b0;
      gray_vsync = 1'b0;
      gray_de    = 1'b1;
      gray_data  = 8'hFF;
      repeat (3) @(negedge clk);
      check_output("reset edge_data", int'(edge_data), 0);
      check_output("reset edge_de", int'(edge_de), 0);
      check_output("reset edge_hsync", int'(edge_hsync), 1);
      check_output("reset edge_vsync", int'(edge_vsync), 1);

      gray_hsync = 1'b1;
      gray_vsync = 1'b1;
      gray_de    = 1'b0;
      gray_data  = 8'h00;
      rst_n      = 1'b1;
      repeat (6) @(negedge clk);
      mon_en = 1'b1;

      for (int f = 0; f < NFRAMES; f++) begin
         int lat0;
         int idle0;
         lat0  = lat_err;
         idle0 = idle_err;
         if (frames[f].rst_row >= 0) mon_en = 1'b0;
         apply_stimulus(frames[f].pattern, frames[f].level, frames[f].rst_row, frames[f].rst_col);
         if (frames[f].exp_ones >= 0) begin
            check_output($sformatf("F%0d edge_de count", f), de_cnt, H * V);
            check_output($sformatf("F%0d edge pixel count", f), one_cnt, frames[f].exp_ones);
            check_output($sformatf("F%0d latency errors", f), lat_err - lat0, 0);
            check_output($sformatf("F%0d data while de low", f), idle_err - idle0, 0);
            foreach (vecs[i]) begin
               if (vecs[i].frame == f) begin
                  check_output($sformatf("F%0d px(%0d,%0d)", f, vecs[i].row, vecs[i].col),
                               int'(cap[vecs[i].row][vecs[i].col]), vecs[i].exp);
               end
            end
         end
         mon_en = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
